// File: rtl/clock_key_controller.sv
// Key front end for the digital clock: debounces mode/add keys, sequences display/set modes, and issues minute/hour increments.
// Outputs are registered one cycle after their cause; there is no backpressure, and held keys auto-repeat on the tick time base.
module clock_key_controller #(
   parameter int DB_CYCLES     = 1024,
   parameter int CNT_W         = 16,
   parameter int REPEAT_DELAY  = 32,
   parameter int REPEAT_PERIOD = 4,
   parameter int BLINK_TICKS   = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        key_mode,
   input  logic        key_add,
   input  logic        tick,
   input  logic [4:0]  hour,
   input  logic [5:0]  minute,
   input  logic [5:0]  second,
   output logic        run_en,
   output logic        minute_inc,
   output logic        hour_inc,
   output logic        clear_seconds,
   output logic [11:0] data_show,
   output logic [1:0]  blank,
   output logic [2:0]  mode
);

   typedef enum logic [2:0] {
      SHOW_TIME = 3'd0,
      SHOW_SEC  = 3'd1,
      SET_MIN   = 3'd2,
      SET_HOUR  = 3'd3,
      STOP      = 3'd4
   } state_t;

   localparam int HW = $clog2(REPEAT_DELAY + 1);
   localparam int PW = $clog2(REPEAT_PERIOD + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);

   // Bit 0 carries the mode key, bit 1 the add key.
   logic [1:0]            sync_q1, sync_q2, db_state, press;
   logic [1:0][CNT_W-1:0] db_cnt;

   logic          mode_press, add_press, add_held;
   state_t        state, state_next, state_prev;
   logic          state_change;
   logic [HW-1:0] hold_cnt;
   logic [PW-1:0] rep_cnt;
   logic          inhibit, rep_fire, inc_evt;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   assign mode_press = press[0];
   assign add_press  = press[1];
   assign add_held   = db_state[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q1  <= '0;
         sync_q2  <= '0;
         db_state <= '0;
         press    <= '0;
         db_cnt   <= '0;
      end else begin
         sync_q1 <= {key_add, key_mode};
         sync_q2 <= sync_q1;
         for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (sync_q2[k] != db_state[k]) begin
               if (db_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
                  db_state[k] <= ~db_state[k];
                  db_cnt[k]   <= '0;
                  press[k]    <= ~db_state[k];
               end else begin
                  db_cnt[k] <= db_cnt[k] + 1'b1;
               end
            end else begin
               db_cnt[k] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= SHOW_TIME;
         state_prev <= SHOW_TIME;
      end else begin
         state      <= state_next;
         state_prev <= state;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SHOW_TIME: if (mode_press) state_next = SHOW_SEC;
         SHOW_SEC:  if (mode_press) state_next = SET_MIN;
         SET_MIN:   if (mode_press) state_next = SET_HOUR;
         SET_HOUR:  if (mode_press) state_next = STOP;
         STOP:      if (mode_press || add_press) state_next = SHOW_TIME;
         default:   state_next = SHOW_TIME;
      endcase
   end

   always_comb begin
      mode  = state;
      blank = 2'b00;
      if (!add_held) begin
         if (state == SET_MIN)
            blank = {1'b0, blink_phase};
         else if (state == SET_HOUR)
            blank = {blink_phase, 1'b0};
      end
   end

   assign state_change = (state_next != state);

   // Repeat fires on the tick completing the delay, then on every period-th tick after it.
   assign rep_fire = tick && add_held && !inhibit &&
                     ((hold_cnt == HW'(REPEAT_DELAY - 1)) ||
                      (hold_cnt == HW'(REPEAT_DELAY) && rep_cnt == PW'(REPEAT_PERIOD - 1)));
   assign inc_evt  = (add_press || rep_fire) && !state_change;

   // A mode change while add is held locks out repeat until the key is released.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_cnt <= '0;
         rep_cnt  <= '0;
         inhibit  <= 1'b0;
      end else if (state_change) begin
         hold_cnt <= '0;
         rep_cnt  <= '0;
         inhibit  <= 1'b1;
      end else if (!add_held) begin
         hold_cnt <= '0;
         rep_cnt  <= '0;
         inhibit  <= 1'b0;
      end else if (tick && !inhibit) begin
         if (hold_cnt != HW'(REPEAT_DELAY)) begin
            hold_cnt <= hold_cnt + 1'b1;
            rep_cnt  <= '0;
         end else if (rep_cnt == PW'(REPEAT_PERIOD - 1)) begin
            rep_cnt <= '0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (tick) begin
         if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_en        <= 1'b1;
         minute_inc    <= 1'b0;
         hour_inc      <= 1'b0;
         clear_seconds <= 1'b0;
         data_show     <= '0;
      end else begin
         run_en        <= (state_next == SHOW_TIME) || (state_next == SHOW_SEC);
         minute_inc    <= inc_evt && (state == SET_MIN);
         hour_inc      <= inc_evt && (state == SET_HOUR);
         clear_seconds <= (state == SET_MIN) && (state_prev != SET_MIN);
         data_show     <= (state == SHOW_SEC) ? {minute, second} : {1'b0, hour, minute};
      end
   end

endmodule

// File: tb/tb_clock_key_controller.sv
// Randomized bench for clock_key_controller: stimulus pushes expected mode/inc events, a negedge monitor pops and compares.
module tb_clock_key_controller;

   localparam int DB     = 4;
   localparam int RD     = 3;
   localparam int RP     = 2;
   localparam int BT     = 2;
   localparam int SETTLE = 12;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        key_mode = 1'b0;
   logic        key_add = 1'b0;
   logic        tick = 1'b0;
   logic [4:0]  hour;
   logic [5:0]  minute;
   logic [5:0]  second = 6'd0;
   logic        run_en, minute_inc, hour_inc, clear_seconds;
   logic [11:0] data_show;
   logic [1:0]  blank;
   logic [2:0]  mode;

   int tests = 0;
   int fails = 0;
   int inc_q[$];
   int mode_q[$];

   // Time datapath stand-in: the bench sets a base, the monitor counts observed increments.
   int min_base = 0, hour_base = 0, min_incs = 0, hour_incs = 0;
   assign minute = 6'((min_base + min_incs) % 60);
   assign hour   = 5'((hour_base + hour_incs) % 24);

   int mdl_mode = 0, mdl_h = 0, tick_total = 0;
   bit mdl_held = 0, mdl_inhibit = 0;

   clock_key_controller #(
      .DB_CYCLES(DB), .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .BLINK_TICKS(BT)
   ) dut (
      .clock(clock), .reset(reset), .key_mode(key_mode), .key_add(key_add), .tick(tick),
      .hour(hour), .minute(minute), .second(second), .run_en(run_en),
      .minute_inc(minute_inc), .hour_inc(hour_inc), .clear_seconds(clear_seconds),
      .data_show(data_show), .blank(blank), .mode(mode)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   int  last_mode = 0, mp1 = 0, mp2 = 0;
   bit  exp_clr;
   always @(negedge clock) begin
      if (minute_inc && hour_inc) check("inc_both", 1, 0);
      if (minute_inc || hour_inc) begin
         if (inc_q.size() == 0) check("inc_unexpected", hour_inc ? 1 : 0, -1);
         else check("inc_kind", hour_inc ? 1 : 0, inc_q.pop_front());
         if (minute_inc) min_incs++;
         if (hour_inc) hour_incs++;
      end
      if (int'(mode) != last_mode) begin
         if (mode_q.size() == 0) check("mode_unexpected", int'(mode), last_mode);
         else check("mode_seq", int'(mode), mode_q.pop_front());
         check("run_en", int'(run_en), (mode <= 3'd1) ? 1 : 0);
         last_mode = int'(mode);
      end
      exp_clr = (mp1 == 2) && (mp2 != 2);
      if (exp_clr || clear_seconds) check("clear_seconds", int'(clear_seconds), int'(exp_clr));
      mp2 = mp1;
      mp1 = int'(mode);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_time(input int h, input int m, input int s);
      min_base  = (m + 60 - (min_incs % 60)) % 60;
      hour_base = (h + 24 - (hour_incs % 24)) % 24;
      second    = 6'(s);
   endtask

   task automatic check_show(input string name, input int h, input int m, input int s);
      logic [11:0] e;
      cyc(2);
      e = (mdl_mode == 1) ? {6'(m), 6'(s)} : {1'b0, 5'(h), 6'(m)};
      check(name, int'(data_show), int'(e));
   endtask

   task automatic check_blank(input string name);
      int ph, e;
      cyc(2);
      ph = (tick_total / BT) % 2;
      e  = 0;
      if (!mdl_held && mdl_mode == 2) e = ph;
      if (!mdl_held && mdl_mode == 3) e = ph * 2;
      check(name, int'(blank), e);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock); #1 tick = 1'b1;
         @(posedge clock); #1 tick = 1'b0;
         tick_total++;
         if (mdl_held && !mdl_inhibit) begin
            mdl_h++;
            if ((mdl_mode == 2 || mdl_mode == 3) && mdl_h >= RD && ((mdl_h - RD) % RP) == 0)
               inc_q.push_back(mdl_mode - 2);
         end
         cyc($urandom_range(0, 3));
      end
   endtask

   task automatic mode_tap();
      mdl_mode = (mdl_mode + 1) % 5;
      mode_q.push_back(mdl_mode);
      if (mdl_held) begin
         mdl_inhibit = 1;
         mdl_h = 0;
      end
      key_mode = 1'b1; cyc(SETTLE);
      key_mode = 1'b0; cyc(SETTLE);
   endtask

   task automatic add_down();
      if (mdl_mode == 4) begin
         mdl_mode = 0;
         mode_q.push_back(0);
         mdl_inhibit = 1;
      end else if (mdl_mode == 2 || mdl_mode == 3) begin
         inc_q.push_back(mdl_mode - 2);
      end
      mdl_held = 1;
      mdl_h = 0;
      key_add = 1'b1; cyc(SETTLE);
   endtask

   task automatic add_up();
      mdl_held = 0;
      mdl_inhibit = 0;
      key_add = 1'b0; cyc(SETTLE);
   endtask

   task automatic do_reset();
      if (mdl_mode != 0) mode_q.push_back(0);
      mdl_mode = 0;
      @(posedge clock); #4 reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tick_total = 0;
      mdl_h = 0;
      mdl_inhibit = 0;
      cyc(1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int h, m, s, n;
      #12;
      check("rst_mode", int'(mode), 0);
      check("rst_run_en", int'(run_en), 1);
      check("rst_incs", int'({minute_inc, hour_inc, clear_seconds}), 0);
      check("rst_data_show", int'(data_show), 0);
      check("rst_blank", int'(blank), 0);
      @(negedge clock); reset = 1'b1;
      cyc(2);

      // Bouncing mode key, then a clean hold: exactly one advance.
      h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
      set_time(h, m, s);
      for (int i = 0; i < 20; i++) begin
         key_mode = ~key_mode;
         cyc(1);
      end
      check("t1_no_bounce_change", int'(mode), 0);
      mode_tap();
      check("t1_mode", int'(mode), 1);
      check_show("t1_show_sec", h, m, s);

      // Five clean presses from reset; monitor checks sequence, run_en, clear_seconds.
      do_reset();
      for (int i = 0; i < 5; i++) mode_tap();
      check("t2_mode_back", int'(mode), 0);
      h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
      set_time(h, m, s);
      check_show("t2_show_time", h, m, s);
      add_down(); add_up();
      mode_tap();
      add_down(); add_up();
      check("t2_add_ignored", int'(mode), 1);
      check_show("t2_show_sec", h, m, s);
      mode_tap(); mode_tap(); mode_tap();
      check("t2_stop_run_en", int'(run_en), 0);
      add_down(); add_up();
      check("t2_stop_add", int'(mode), 0);

      // SET_MIN blinking, then minute 59 wraps to 0 on a single press.
      mode_tap(); mode_tap();
      for (int i = 0; i < 4; i++) begin
         ticks(1);
         check_blank("t3_blank_min");
      end
      h = $urandom_range(0, 23); s = $urandom_range(0, 59);
      set_time(h, 59, s);
      add_down();
      add_up();
      check_show("t3_minute_wrap", h, 0, s);

      // Held add in SET_MIN, then mode press: no hour repeat until re-press.
      add_down();
      ticks($urandom_range(0, 6));
      mode_tap();
      check("t5_mode", int'(mode), 3);
      ticks(8);
      check_blank("t5_blank_held");
      add_up();
      add_down();
      add_up();

      // SET_HOUR hold for 10 ticks: initial pulse plus ticks 3,5,7,9.
      add_down();
      for (int i = 0; i < 5; i++) begin
         ticks(2);
         check_blank("t4_blank_held");
      end
      add_up();
      cyc(2);
      check("t4_queue_drained", inc_q.size(), 0);
      for (int i = 0; i < 3; i++) begin
         n = $urandom_range(0, 12);
         add_down(); ticks(n); add_up();
      end
      ticks(1);
      check_blank("t4_blank_hour");
      ticks(1);
      check_blank("t4_blank_hour2");

      // Simultaneous mode and add press in SET_MIN: mode wins, no increments.
      mode_tap(); mode_tap(); mode_tap(); mode_tap();
      check("sim_in_set_min", int'(mode), 2);
      mdl_mode = 3;
      mode_q.push_back(3);
      mdl_held = 1; mdl_inhibit = 1; mdl_h = 0;
      key_mode = 1'b1; key_add = 1'b1; cyc(SETTLE);
      key_mode = 1'b0; cyc(SETTLE);
      ticks(6);
      add_up();
      check("sim_mode", int'(mode), 3);

      // Reset mid-repeat in SET_HOUR with the add key still held.
      add_down();
      ticks(5);
      cyc(4);
      mode_q.push_back(0);
      mdl_mode = 0;
      #3 reset = 1'b0;
      #1;
      check("t6_mode", int'(mode), 0);
      check("t6_run_en", int'(run_en), 1);
      check("t6_incs", int'({minute_inc, hour_inc, clear_seconds}), 0);
      check("t6_data_show", int'(data_show), 0);
      check("t6_blank", int'(blank), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tick_total = 0; mdl_h = 0; mdl_inhibit = 0;
      cyc(SETTLE);
      ticks(8);
      check("t6_mode_after", int'(mode), 0);
      add_up();

      cyc(5);
      check("inc_queue_empty", inc_q.size(), 0);
      check("mode_queue_empty", mode_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/clock_key_controller.md
Name: clock_key_controller

Overview:
- Key-driven mode and time-set controller for the digital clock.
- Debounces the mode and add keys, sequences the display/set modes, and gates second counting.
- Issues single-cycle increment pulses (with auto-repeat on a held add key) to the minute/hour counters.
- Selects the 12-bit `data_show` word and the digit-blanking mask for `segment_show`.

Parameters:
- DB_CYCLES, 1024: consecutive stable cycles required before a debounced key changes state.
- CNT_W, 16: width of the debounce counters (must hold DB_CYCLES).
- REPEAT_DELAY, 32: ticks an add key must stay held before auto-repeat starts.
- REPEAT_PERIOD, 4: ticks between auto-repeat pulses.
- BLINK_TICKS, 8: ticks per blink half-period.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_mode  in  1  raw mode key, 1 = pressed, asynchronous.
- key_add  in  1  raw add key, 1 = pressed, asynchronous.
- tick  in  1  one-cycle strobe from the clock-counter wrap (time base).
- hour  in  5  current hour, 0..23.
- minute  in  6  current minute, 0..59.
- second  in  6  current second, 0..59.
- run_en  out  1  1 = time counters may advance.
- minute_inc  out  1  one-cycle minute increment; the datapath wraps 59->0 with no carry.
- hour_inc  out  1  one-cycle hour increment; the datapath wraps 23->0.
- clear_seconds  out  1  one-cycle request to zero the seconds counter.
- data_show  out  12  display word: {upper 6 bits, lower 6 bits}.
- blank  out  2  bit0 blanks the lower digit pair, bit1 blanks the upper digit pair.
- mode  out  3  current state encoding.

Behaviour:
- Reset values (asserted while reset=0, asynchronous):
  - mode = SHOW_TIME(0), run_en = 1.
  - minute_inc = hour_inc = clear_seconds = 0.
  - data_show = 0, blank = 0.
  - All counters, synchronisers and debounced states = 0.
- Input sync: each raw key passes through a 2-flop synchroniser.
- Debounce (per key):
  - The counter increments while the synchronised key differs from the debounced state, and clears otherwise.
  - When the counter reaches DB_CYCLES-1, the debounced state flips and the counter clears.
  - press = one-cycle pulse on a debounced 0->1 transition. No release pulse.
- States (mode encoding): SHOW_TIME=0, SHOW_SEC=1, SET_MIN=2, SET_HOUR=3, STOP=4. Codes 5-7 are illegal; they go to SHOW_TIME on the next cycle.
- A mode press advances the state 0->1->2->3->4->0.
- Add press in STOP -> SHOW_TIME.
- run_en is registered: 1 in SHOW_TIME and SHOW_SEC, 0 in SET_MIN, SET_HOUR and STOP.
- clear_seconds pulses for exactly one cycle, on the cycle after entering SET_MIN.
- Add key in SET_MIN / SET_HOUR:
  - A press gives one minute_inc (resp. hour_inc) pulse, 1 cycle after the press pulse.
  - While the add key stays debounced-pressed, a hold counter counts ticks.
  - After REPEAT_DELAY ticks, one pulse is issued every REPEAT_PERIOD ticks.
  - The hold counter saturates and clears on release.
- Add presses in SHOW_TIME and SHOW_SEC are ignored.
- Simultaneous mode and add press in the same cycle: mode wins; the add press is discarded.
- On any mode change:
  - The hold counter clears.
  - Auto-repeat is inhibited until the add key is released and pressed again.
- No inc pulse is ever issued in the cycle a state change occurs.
- Blink:
  - blink_phase toggles every BLINK_TICKS ticks, always running.
  - SET_MIN: blank = {0, blink_phase}. SET_HOUR: blank = {blink_phase, 0}. Other states: blank = 00.
  - blank is forced to 00 while the add key is debounced-pressed.
- data_show, registered with 1-cycle latency from its inputs:
  - SHOW_TIME, SET_MIN, SET_HOUR, STOP: {1'b0, hour, minute}.
  - SHOW_SEC: {minute, second}.
- Reset asserted mid-hold or mid-debounce aborts all activity; no inc pulse is issued after reset release until a fresh debounced press.

Test Plan:
1. DB_CYCLES=4, toggle key_mode every cycle for 20 cycles, then hold 1 -> no mode change during bouncing; exactly one advance to SHOW_SEC. mode==1, data_show=={minute,second}.
2. Five clean mode presses from reset -> mode sequence 1,2,3,4,0. clear_seconds high exactly 1 cycle after entering SET_MIN. run_en sequence 1,0,0,0,1.
3. SET_MIN, minute=59, single add press -> exactly one minute_inc pulse, no hour_inc. Model minute becomes 0, hour unchanged.
4. SET_HOUR, REPEAT_DELAY=3, REPEAT_PERIOD=2, add held for 10 ticks -> 1 initial pulse plus pulses at ticks 3,5,7,9 (5 total). blank==00 throughout the hold.
5. SET_MIN, add held, then a mode press -> transition to SET_HOUR with zero hour_inc until the add key is released and re-pressed.
6. reset pulled low mid-repeat in SET_HOUR -> all outputs at reset values immediately (asynchronously), mode==0, run_en==1, no inc pulses after release while add is still held.
